// File: rtl/dm_ctrl.sv
// Data-memory controller: single-cycle byte-lane stores, registered loads with
// sign/zero extension returned over a valid/ready handshake.
module dm_ctrl #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ext,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        err,
  output logic        dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic {
    IDLE     = 1'b0,
    LOAD_RSP = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic        accept, be_ok, in_range, reject, st_go, ld_go;
  logic [AW-1:0] widx;
  logic [31:0] wshift, rd_word, rd_byte_sh, rd_half_sh, ld_ext, rdata_d;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        err_q;

  // Handshake: a request transfers on any rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE, and the requester
  // must hold the request stable until it transfers.
  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign dbg_state = state_q;

  always_comb begin
    be_ok = 1'b0;
    case (req_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
      default:                   be_ok = 1'b0;
    endcase
  end

  assign in_range = ({2'b00, req_addr[31:2]} < 32'(DEPTH_WORDS));
  assign reject   = !be_ok || !in_range;
  assign st_go    = accept && req_we && !reject;
  assign ld_go    = accept && !req_we;
  assign widx     = req_addr[AW+1:2];

  // Store width comes from how many lanes are enabled, not from req_ext.
  always_comb begin
    wshift = req_wdata;
    case ($countones(req_be))
      1:       wshift = req_wdata << {req_addr[1:0], 3'b000};
      2:       wshift = req_wdata << {req_addr[1], 4'b0000};
      default: wshift = req_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (st_go && req_be[i]) mem_q[widx][8*i +: 8] <= wshift[8*i +: 8];
    end
  end

  assign rd_word    = mem_q[widx];
  assign rd_byte_sh = rd_word >> {req_addr[1:0], 3'b000};
  assign rd_half_sh = rd_word >> {req_addr[1], 4'b0000};

  always_comb begin
    ld_ext = rd_word;
    case (req_ext)
      3'd1:    ld_ext = {24'b0, rd_byte_sh[7:0]};
      3'd2:    ld_ext = {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]};
      3'd3:    ld_ext = {16'b0, rd_half_sh[15:0]};
      3'd4:    ld_ext = {{16{rd_half_sh[15]}}, rd_half_sh[15:0]};
      default: ld_ext = rd_word;
    endcase
    rdata_d = reject ? 32'b0 : ld_ext;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (ld_go) state_d = LOAD_RSP;
      LOAD_RSP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // The response is captured at the accept edge so it is presented, registered,
  // during the single LOAD_RSP cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= ld_go;
      err_q       <= accept && reject;
      if (ld_go) rsp_rdata_q <= rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: vector table of stores/loads, random word traffic against a
// small memory model, and hand-written reset and handshake sequences.
module tb_dm_ctrl;

  localparam int DEPTH = 256;

  logic        clk, reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  logic [2:0]  req_ext;
  logic        rsp_valid, err, dbg_state;

  int n_checks = 0;
  int n_errs   = 0;
  logic [31:0] exp_q[$];

  dm_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .req_ext   (req_ext),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .err       (err),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every response pulse pops one expected load result.
  always @(negedge clk) begin
    if (reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL rsp_unexpected: got rdata 0x%08h expected no response", rsp_rdata);
      end else begin
        chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
      end
    end
  end

  // Drives one request at a falling edge, waiting (bounded) for req_ready.
  task automatic drive(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [2:0] ext);
    int w;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_drive", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wdata;
    req_ext   = ext;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic exp_err);
    drive(1'b1, addr, be, wdata, 3'd0);
    @(posedge clk); #1;
    chk("store_err", {31'b0, err}, {31'b0, exp_err});
    chk("store_no_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("store_ready", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [3:0] be, input logic [2:0] ext,
                         input logic [31:0] exp_data, input logic exp_err);
    drive(1'b0, addr, be, 32'h0, ext);
    @(posedge clk);
    exp_q.push_back(exp_data);
    #1;
    chk("load_err", {31'b0, err}, {31'b0, exp_err});
    chk("load_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("load_ready_low", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("load_rsp_done", {30'b0, rsp_valid, req_ready}, 32'd1);
    chk("load_err_pulse", {31'b0, err}, 32'd0);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  ext;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] model[16];

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0;
    req_wdata = '0;   req_ext = '0;
    reset = 1'b0;
    #12;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_outputs", {30'b0, rsp_valid, err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    vecs = '{
      '{1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 3'd0, 32'h0,        1'b0},
      '{1'b0, 32'h10, 4'b1111, 32'h0,        3'd0, 32'hDEADBEEF, 1'b0},
      '{1'b1, 32'h20, 4'b1111, 32'h0,        3'd0, 32'h0,        1'b0},
      '{1'b1, 32'h23, 4'b1000, 32'h80,       3'd0, 32'h0,        1'b0},
      '{1'b0, 32'h23, 4'b1000, 32'h0,        3'd2, 32'hFFFFFF80, 1'b0},
      '{1'b0, 32'h23, 4'b1000, 32'h0,        3'd1, 32'h00000080, 1'b0},
      '{1'b0, 32'h20, 4'b1111, 32'h0,        3'd0, 32'h80000000, 1'b0},
      '{1'b1, 32'h30, 4'b1111, 32'h12345678, 3'd0, 32'h0,        1'b0},
      '{1'b1, 32'h32, 4'b1100, 32'h8001,     3'd0, 32'h0,        1'b0},
      '{1'b0, 32'h32, 4'b1100, 32'h0,        3'd4, 32'hFFFF8001, 1'b0},
      '{1'b0, 32'h32, 4'b1100, 32'h0,        3'd3, 32'h00008001, 1'b0},
      '{1'b0, 32'h30, 4'b0011, 32'h0,        3'd3, 32'h00005678, 1'b0},
      '{1'b1, 32'h40, 4'b1111, 32'hA5A5A5A5, 3'd0, 32'h0,        1'b0},
      '{1'b1, 32'h40, 4'b0101, 32'hFFFFFFFF, 3'd0, 32'h0,        1'b1},
      '{1'b0, 32'h40, 4'b1111, 32'h0,        3'd0, 32'hA5A5A5A5, 1'b0},
      '{1'b0, 32'h400, 4'b1111, 32'h0,       3'd0, 32'h0,        1'b1},
      '{1'b0, 32'h10, 4'b0000, 32'h0,        3'd0, 32'h0,        1'b1},
      '{1'b1, 32'h3FC, 4'b1111, 32'h11223344, 3'd0, 32'h0,       1'b0},
      '{1'b0, 32'h3FC, 4'b1111, 32'h0,       3'd5, 32'h11223344, 1'b0},
      '{1'b1, 32'h400, 4'b1111, 32'hFFFFFFFF, 3'd0, 32'h0,       1'b1},
      '{1'b0, 32'h3FF, 4'b1000, 32'h0,       3'd2, 32'h00000011, 1'b0}
    };
    foreach (vecs[i]) begin
      if (vecs[i].we) do_store(vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].exp_err);
      else do_load(vecs[i].addr, vecs[i].be, vecs[i].ext, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Back-to-back stores with the request held valid across cycles.
    do_store(32'h51, 4'b0010, 32'h11,   1'b0);
    do_store(32'h52, 4'b1100, 32'hBEEF, 1'b0);
    do_store(32'h50, 4'b0001, 32'h22,   1'b0);
    do_load(32'h50, 4'b1111, 3'd0, 32'hBEEF1122, 1'b0);
    do_store(32'h54, 4'b1111, 32'h0BADF00D, 1'b0);
    do_load(32'h51, 4'b0010, 3'd2, 32'h00000011, 1'b0);
    do_load(32'h50, 4'b0011, 3'd4, 32'h00001122, 1'b0);
    do_load(32'h50, 4'b1111, 3'd7, 32'hBEEF1122, 1'b0);
    idle();

    // Random word traffic against a 16-word model at 0x100.
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      do_store(32'h100 + 32'(4 * i), 4'b1111, model[i], 1'b0);
    end
    for (int i = 0; i < 24; i++) begin
      int k;
      k = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        model[k] = $urandom;
        do_store(32'h100 + 32'(4 * k), 4'b1111, model[k], 1'b0);
      end else begin
        do_load(32'h100 + 32'(4 * k), 4'b1111, 3'd0, model[k], 1'b0);
      end
    end
    idle();

    // Asynchronous reset in the middle of a rejected load's response cycle.
    drive(1'b0, 32'h400, 4'b1111, 32'h0, 3'd0);
    @(posedge clk); #1;
    chk("pre_rst_err", {30'b0, err, rsp_valid}, 32'd3);
    req_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("async_rst_outputs", {29'b0, rsp_valid, err, req_ready}, 32'd1);
    chk("async_rst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    do_store(32'h60, 4'b1111, 32'hCAFEF00D, 1'b0);
    do_load(32'h60, 4'b1111, 3'd0, 32'hCAFEF00D, 1'b0);
    do_load(32'h10, 4'b1111, 3'd0, 32'hDEADBEEF, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
